matrix_uart_parser: RTL and testbench



---
 rtl/project_pkg.sv | 33 +++
 rtl/matrix_uart_parser_classifier.sv | 29 ++
 rtl/matrix_uart_parser.sv | 226 ++++++++++++++++++++++
 tb/tb_matrix_uart_parser.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// Shared types and constants for the matrix UART text path.
//   matrix_element_t : signed 8-bit matrix element
//   parse_state_t    : parser FSM states
//   parse_err_t      : parser error codes reported on err_code
//   ASCII_*          : control and punctuation byte values used by the parser
package project_pkg;

   typedef logic signed [7:0] matrix_element_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SIGN   = 2'd1,
      DIGITS = 2'd2,
      SKIP   = 2'd3
   } parse_state_t;

   typedef enum logic [1:0] {
      ERR_BAD_CHAR   = 2'd0,
      ERR_TOO_MANY   = 2'd1,
      ERR_RANGE      = 2'd2,
      ERR_LONE_SIGN  = 2'd3
   } parse_err_t;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_COMMA = 8'h2C;
   localparam logic [7:0] ASCII_TAB   = 8'h09;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

endpackage

// File: rtl/matrix_uart_parser_classifier.sv
// Combinational byte classifier for the matrix UART parser.
//   rx_data   : received byte
//   is_digit  : '0'..'9'
//   is_sign   : '-'
//   is_sep    : space, ',' or TAB
//   is_nl     : CR or LF
//   digit_val : binary value of a digit byte (only meaningful with is_digit)
module ascii_char_classifier
   import project_pkg::*;
(
   input  logic [7:0] rx_data,
   output logic       is_digit,
   output logic       is_sign,
   output logic       is_sep,
   output logic       is_nl,
   output logic [3:0] digit_val
);

   logic [7:0] offset;

   assign offset    = rx_data - ASCII_ZERO;
   assign is_digit  = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
   assign is_sign   = (rx_data == ASCII_MINUS);
   assign is_sep    = (rx_data == ASCII_SPACE) || (rx_data == ASCII_COMMA) ||
                      (rx_data == ASCII_TAB);
   assign is_nl     = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
   assign digit_val = offset[3:0];

endmodule

// File: rtl/matrix_uart_parser.sv
// Parses ASCII signed decimal integers from the UART RX byte stream into
// matrix elements, reporting line boundaries and rejected tokens.
//   clk, rst   : clock, asynchronous active-high reset
//   rx_data    : received byte, qualified by rx_valid
//   clear      : synchronous abort of the partial token and line state
//   num_data   : last parsed value (two's complement)
//   num_valid  : one-cycle pulse, num_data valid
//   num_eol    : with num_valid, token ended by CR/LF
//   line_end   : one-cycle pulse, CR/LF with no pending token
//   err        : one-cycle pulse, token rejected; err_code gives the reason
//   line_cnt   : tokens accepted on the current line (saturating)
//
// state  | meaning
// IDLE   | between tokens
// SIGN   | '-' seen, waiting for the first digit
// DIGITS | accumulating digits of a token
// SKIP   | discarding the rest of a rejected token
module matrix_uart_parser
   import project_pkg::*;
#(
   parameter int MAX_DIGITS = 3,
   parameter int ELEM_MAX   = 127,
   parameter int ELEM_MIN   = -128,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             clear,
   output logic [7:0]       num_data,
   output logic             num_valid,
   output logic             num_eol,
   output logic             line_end,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] line_cnt
);

   localparam int ND_W = $clog2(MAX_DIGITS + 1);
   localparam logic [9:0] POS_LIMIT = 10'(ELEM_MAX);
   localparam logic [9:0] NEG_LIMIT = 10'(-ELEM_MIN);

   logic       is_digit, is_sign, is_sep, is_nl;
   logic [3:0] digit_val;

   ascii_char_classifier u_class (
      .rx_data   (rx_data),
      .is_digit  (is_digit),
      .is_sign   (is_sign),
      .is_sep    (is_sep),
      .is_nl     (is_nl),
      .digit_val (digit_val)
   );

   parse_state_t    state, state_n;
   logic [9:0]      acc, acc_n;
   logic            neg, neg_n;
   logic [ND_W-1:0] ndig, ndig_n;
   logic            prev_cr, prev_cr_n;
   logic [CNT_W-1:0] cnt_n;
   logic [7:0]      nd_n;
   logic            nv_n, eol_n, le_n, err_n;
   parse_err_t      err_code_q, ec_n;

   logic [9:0]       acc_dig;
   logic [9:0]       digit_ext;
   logic             in_range;
   logic [7:0]       signed_val;
   logic [CNT_W-1:0] cnt_inc;
   logic             drop;

   assign digit_ext  = {6'd0, digit_val};
   assign acc_dig    = (acc * 10'd10) + digit_ext;
   assign in_range   = neg ? (acc <= NEG_LIMIT) : (acc <= POS_LIMIT);
   assign signed_val = neg ? (8'd0 - acc[7:0]) : acc[7:0];
   assign cnt_inc    = (line_cnt == '1) ? line_cnt : line_cnt + CNT_W'(1);

   always_comb begin
      state_n   = state;
      acc_n     = acc;
      neg_n     = neg;
      ndig_n    = ndig;
      prev_cr_n = prev_cr;
      cnt_n     = line_cnt;
      nd_n      = num_data;
      ec_n      = err_code_q;
      nv_n      = 1'b0;
      eol_n     = 1'b0;
      le_n      = 1'b0;
      err_n     = 1'b0;
      drop      = 1'b0;

      if (clear) begin
         state_n   = IDLE;
         prev_cr_n = 1'b0;
         cnt_n     = '0;
         drop      = 1'b1;
      end else if (rx_valid) begin
         // LF right after CR belongs to the same line break
         if ((rx_data == ASCII_LF) && prev_cr) begin
            prev_cr_n = 1'b0;
         end else begin
            prev_cr_n = (rx_data == ASCII_CR);
            case (state)
               IDLE: begin
                  if (is_digit) begin
                     state_n = DIGITS;
                     acc_n   = digit_ext;
                     ndig_n  = ND_W'(1);
                  end else if (is_sign) begin
                     state_n = SIGN;
                     neg_n   = 1'b1;
                  end else if (is_nl) begin
                     le_n  = 1'b1;
                     cnt_n = '0;
                  end else if (!is_sep) begin
                     err_n   = 1'b1;
                     ec_n    = ERR_BAD_CHAR;
                     state_n = SKIP;
                  end
               end
               SIGN: begin
                  if (is_digit) begin
                     state_n = DIGITS;
                     acc_n   = digit_ext;
                     ndig_n  = ND_W'(1);
                  end else if (is_sep || is_nl) begin
                     err_n   = 1'b1;
                     ec_n    = ERR_LONE_SIGN;
                     state_n = IDLE;
                     drop    = 1'b1;
                     if (is_nl) cnt_n = '0;
                  end else begin
                     err_n   = 1'b1;
                     ec_n    = ERR_BAD_CHAR;
                     state_n = SKIP;
                     drop    = 1'b1;
                  end
               end
               DIGITS: begin
                  if (is_digit) begin
                     if (ndig < ND_W'(MAX_DIGITS)) begin
                        acc_n  = acc_dig;
                        ndig_n = ndig + ND_W'(1);
                     end else begin
                        err_n   = 1'b1;
                        ec_n    = ERR_TOO_MANY;
                        state_n = SKIP;
                        drop    = 1'b1;
                     end
                  end else if (is_sep || is_nl) begin
                     if (in_range) begin
                        nv_n  = 1'b1;
                        nd_n  = signed_val;
                        cnt_n = cnt_inc;
                     end else begin
                        err_n = 1'b1;
                        ec_n  = ERR_RANGE;
                     end
                     if (is_nl) begin
                        eol_n = in_range;
                        cnt_n = '0;
                     end
                     state_n = IDLE;
                     drop    = 1'b1;
                  end else begin
                     err_n   = 1'b1;
                     ec_n    = ERR_BAD_CHAR;
                     state_n = SKIP;
                     drop    = 1'b1;
                  end
               end
               SKIP: begin
                  if (is_sep) begin
                     state_n = IDLE;
                  end else if (is_nl) begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end

      if (drop) begin
         acc_n  = '0;
         neg_n  = 1'b0;
         ndig_n = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         neg        <= 1'b0;
         ndig       <= '0;
         prev_cr    <= 1'b0;
         line_cnt   <= '0;
         num_data   <= '0;
         num_valid  <= 1'b0;
         num_eol    <= 1'b0;
         line_end   <= 1'b0;
         err        <= 1'b0;
         err_code_q <= ERR_BAD_CHAR;
      end else begin
         state      <= state_n;
         acc        <= acc_n;
         neg        <= neg_n;
         ndig       <= ndig_n;
         prev_cr    <= prev_cr_n;
         line_cnt   <= cnt_n;
         num_data   <= nd_n;
         num_valid  <= nv_n;
         num_eol    <= eol_n;
         line_end   <= le_n;
         err        <= err_n;
         err_code_q <= ec_n;
      end
   end

   assign err_code = err_code_q;

endmodule

// File: tb/tb_matrix_uart_parser.sv
module tb_matrix_uart_parser;
   import project_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       clear;
   logic [7:0] num_data;
   logic       num_valid;
   logic       num_eol;
   logic       line_end;
   logic       err;
   logic [1:0] err_code;
   logic [3:0] line_cnt;

   int n_total = 0;
   int n_pass  = 0;

   matrix_uart_parser dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .clear     (clear),
      .num_data  (num_data),
      .num_valid (num_valid),
      .num_eol   (num_eol),
      .line_end  (line_end),
      .err       (err),
      .err_code  (err_code),
      .line_cnt  (line_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] ch;
      logic       vld;
      logic       clr;
      logic       nv;
      logic [7:0] nd;
      logic       eol;
      logic       le;
      logic       er;
      logic [1:0] ec;
      logic [3:0] cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [7:0] ch, input logic vld, input logic clr,
                               input logic nv, input logic [7:0] nd, input logic eol,
                               input logic le, input logic er, input logic [1:0] ec,
                               input logic [3:0] cnt);
      vec_t v;
      v.ch = ch; v.vld = vld; v.clr = clr; v.nv = nv; v.nd = nd; v.eol = eol;
      v.le = le; v.er = er; v.ec = ec; v.cnt = cnt;
      return v;
   endfunction

   function automatic vec_t q(input logic [7:0] ch, input logic [3:0] cnt);
      return mk(ch, 1, 0, 0, 8'h00, 0, 0, 0, 2'd0, cnt);
   endfunction
   function automatic vec_t val(input logic [7:0] ch, input logic [7:0] d,
                                input logic eol, input logic [3:0] cnt);
      return mk(ch, 1, 0, 1, d, eol, 0, 0, 2'd0, cnt);
   endfunction
   function automatic vec_t le(input logic [7:0] ch);
      return mk(ch, 1, 0, 0, 8'h00, 0, 1, 0, 2'd0, 4'd0);
   endfunction
   function automatic vec_t er(input logic [7:0] ch, input logic [1:0] code,
                               input logic [3:0] cnt);
      return mk(ch, 1, 0, 0, 8'h00, 0, 0, 1, code, cnt);
   endfunction

   task automatic check(input string name, input vec_t v, input logic full);
      logic ok;
      ok = (num_valid === v.nv) && (num_eol === v.eol) && (line_end === v.le) &&
           (err === v.er) && (line_cnt === v.cnt);
      if (v.nv || full) ok = ok && (num_data === v.nd);
      if (v.er || full) ok = ok && (err_code === v.ec);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got nv=%0b nd=%02h eol=%0b le=%0b err=%0b ec=%0d cnt=%0d want nv=%0b nd=%02h eol=%0b le=%0b err=%0b ec=%0d cnt=%0d",
                    name, num_valid, num_data, num_eol, line_end, err, err_code, line_cnt,
                    v.nv, v.nd, v.eol, v.le, v.er, v.ec, v.cnt);
   endtask

   task automatic apply(input string name, input vec_t v);
      @(negedge clk);
      rx_data  = v.ch;
      rx_valid = v.vld;
      clear    = v.clr;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      clear    = 1'b0;
      check(name, v, 1'b0);
   endtask

   localparam logic [7:0] CR  = 8'h0D;
   localparam logic [7:0] LF  = 8'h0A;
   localparam logic [7:0] TAB = 8'h09;

   initial begin
      vec_t zero_v;
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; clear = 1'b0;

      // "12 -7,3\r\n"
      vq.push_back(q("1",0)); vq.push_back(q("2",0)); vq.push_back(val(" ",8'd12,0,1));
      vq.push_back(q("-",1)); vq.push_back(q("7",1)); vq.push_back(val(",",8'hF9,0,2));
      vq.push_back(q("3",2)); vq.push_back(val(CR,8'd3,1,0)); vq.push_back(q(LF,0));
      vq.push_back(mk(8'h00,0,0,0,8'h00,0,0,0,2'd0,0));
      // "127 128 -128 -129 "
      vq.push_back(q("1",0)); vq.push_back(q("2",0)); vq.push_back(q("7",0));
      vq.push_back(val(" ",8'd127,0,1));
      vq.push_back(q("1",1)); vq.push_back(q("2",1)); vq.push_back(q("8",1));
      vq.push_back(er(" ",2,1));
      vq.push_back(q("-",1)); vq.push_back(q("1",1)); vq.push_back(q("2",1)); vq.push_back(q("8",1));
      vq.push_back(val(" ",8'h80,0,2));
      vq.push_back(q("-",2)); vq.push_back(q("1",2)); vq.push_back(q("2",2)); vq.push_back(q("9",2));
      vq.push_back(er(" ",2,2));
      // "1234 5\n"
      vq.push_back(q("1",2)); vq.push_back(q("2",2)); vq.push_back(q("3",2));
      vq.push_back(er("4",1,2)); vq.push_back(q(" ",2)); vq.push_back(q("5",2));
      vq.push_back(val(LF,8'd5,1,0));
      // "- \n\n"
      vq.push_back(q("-",0)); vq.push_back(er(" ",3,0)); vq.push_back(le(LF)); vq.push_back(le(LF));
      // "4a5 9 "
      vq.push_back(q("4",0)); vq.push_back(er("a",0,0)); vq.push_back(q("5",0));
      vq.push_back(q(" ",0)); vq.push_back(q("9",0)); vq.push_back(val(" ",8'd9,0,1));
      // "45" then clear together with ' ', then "6 "
      vq.push_back(q("4",1)); vq.push_back(q("5",1));
      vq.push_back(mk(" ",1,1,0,8'h00,0,0,0,2'd0,0));
      vq.push_back(q("6",0)); vq.push_back(val(" ",8'd6,0,1));
      // "-0\r", "\r\n\n": -0 is 0, CR line_end, LF swallowed, next LF counts
      vq.push_back(q("-",1)); vq.push_back(q("0",1)); vq.push_back(val(CR,8'd0,1,0));
      vq.push_back(le(CR)); vq.push_back(q(LF,0)); vq.push_back(le(LF));
      // "007," "999 " "--5\n"
      vq.push_back(q("0",0)); vq.push_back(q("0",0)); vq.push_back(q("7",0));
      vq.push_back(val(",",8'd7,0,1));
      vq.push_back(q("9",1)); vq.push_back(q("9",1)); vq.push_back(q("9",1));
      vq.push_back(er(" ",2,1));
      vq.push_back(q("-",1)); vq.push_back(er("-",0,1)); vq.push_back(q("5",1)); vq.push_back(q(LF,0));
      // "1 -\nx\t2\t"
      vq.push_back(q("1",0)); vq.push_back(val(" ",8'd1,0,1)); vq.push_back(q("-",1));
      vq.push_back(er(LF,3,0)); vq.push_back(er("x",0,0)); vq.push_back(q(TAB,0));
      vq.push_back(q("2",0)); vq.push_back(val(TAB,8'd2,0,1));

      zero_v = mk(8'h00,0,0,0,8'h00,0,0,0,2'd0,0);

      #12;
      check("reset_state", zero_v, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++)
         apply($sformatf("vec%0d", i), vq[i]);

      // line_cnt saturation after 15 tokens, then bare LF clears it
      apply("sat_lf", le(LF));
      for (int i = 0; i < 16; i++) begin
         apply($sformatf("sat_d%0d", i), q("1", 4'((i > 15) ? 15 : i)));
         apply($sformatf("sat_s%0d", i), val(" ", 8'd1, 0, 4'((i + 1 > 15) ? 15 : i + 1)));
      end
      apply("sat_clr", le(LF));

      // reset mid-token discards "-3"
      apply("rst_tok_a", q("2",0));
      apply("rst_tok_b", val(" ",8'd2,0,1));
      apply("rst_tok_c", q("-",1));
      apply("rst_tok_d", q("3",1));
      #2;
      rst = 1'b1;
      #2;
      check("rst_outputs", zero_v, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      apply("post_rst_a", q("4",0));
      apply("post_rst_b", val(" ",8'd4,0,1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
